// File: rtl/uut_result_uart.sv
// Result-logging UART transmitter: captures each completed UUT result into a small FIFO
// and streams it to the host as a 10-byte 8N1 frame (0xA5, 8 payload bytes MSB first, XOR checksum).
module uut_result_uart #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_uut,
  input  logic              end_uut,
  input  logic [DATA_W-1:0] block_o_uut,
  output logic              tx,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       count_o
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB  = DATA_W / 8;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t            state;
  logic              end_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fcnt;
  logic              cap, pop, push, full, nempty;

  logic [DATA_W-1:0] shreg;
  logic [7:0]        byte_sr, csum;
  logic [3:0]        byte_idx;
  logic [2:0]        bit_idx;
  logic [CW-1:0]     baud_cnt;
  logic              bit_end;

  function automatic logic [7:0] xsum(input logic [DATA_W-1:0] d);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) s ^= d[8*i +: 8];
    return s;
  endfunction

  // Capture on the rising edge of end_uut, ignored while the UUT is held in reset
  assign cap     = end_uut & ~end_q & ~rst_uut;
  assign full    = (fcnt == (AW+1)'(DEPTH));
  assign nempty  = (fcnt != '0);
  assign pop     = (state == LOAD);
  assign push    = cap & (~full | pop);
  assign bit_end = (baud_cnt == CW'(DIV - 1));
  assign busy    = (state != IDLE) | nempty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= block_o_uut;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      end_q <= end_uut;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fcnt <= fcnt + (AW+1)'(push) - (AW+1)'(pop);
      if (cap && full && !pop) overflow <= 1'b1;
    end
  end

  // byte_sr holds the byte on the line; shreg feeds payload bytes MSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      count_o  <= '0;
      shreg    <= '0;
      byte_sr  <= '0;
      csum     <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (nempty) state <= LOAD;
        LOAD: begin
          shreg    <= mem[rd_ptr];
          csum     <= xsum(mem[rd_ptr]);
          byte_idx <= '0;
          byte_sr  <= SYNC;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= byte_sr[0];
            byte_sr  <= {1'b0, byte_sr[7:1]};
            bit_idx  <= '0;
            state    <= DATA;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= byte_sr[0];
              byte_sr <= {1'b0, byte_sr[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx != 4'(NB + 1)) begin
              byte_idx <= byte_idx + 1'b1;
              tx       <= 1'b0;
              state    <= START;
              if (byte_idx == 4'(NB)) byte_sr <= csum;
              else begin
                byte_sr <= shreg[DATA_W-1 -: 8];
                shreg   <= shreg << 8;
              end
            end else begin
              count_o <= count_o + 1'b1;
              state   <= nempty ? LOAD : IDLE;
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uut_result_uart.sv
// Bench for uut_result_uart: directed scenarios plus random bursts, with a UART decoder
// and a frame model built from the payloads.
module tb_uut_result_uart;
  localparam int DIV = 10;

  logic        clk, rst, rst_uut, end_uut, tx, busy, overflow;
  logic [63:0] block_o_uut;
  logic [15:0] count_o;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0]  byte_q[$];
  int          start_q[$];
  logic [63:0] exp_q[$];

  uut_result_uart #(.CLK_HZ(1000), .BAUD(100), .DATA_W(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rst_uut(rst_uut), .end_uut(end_uut), .block_o_uut(block_o_uut),
    .tx(tx), .busy(busy), .overflow(overflow), .count_o(count_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [63:0] p, input int i);
    logic [7:0] x;
    x = 8'h00;
    if (i == 0) return 8'hA5;
    if (i == 9) begin
      for (int k = 0; k < 8; k++) x ^= p[8*k +: 8];
      return x;
    end
    return p[8*(8-i) +: 8];
  endfunction

  // UART receiver: samples each bit mid-period on the falling clock edge
  int         dpos = 0;
  bit         dact = 0;
  logic [7:0] dsh;
  always @(negedge clk) begin
    if (rst) dact = 0;
    else if (!dact) begin
      if (tx === 1'b0) begin
        dact = 1; dpos = 0; start_q.push_back(cyc);
      end
    end else begin
      dpos++;
      if (dpos == DIV/2) chk("start_bit", 64'(tx), 64'(0));
      for (int k = 1; k <= 8; k++)
        if (dpos == k*DIV + DIV/2) dsh[k-1] = tx;
      if (dpos == 9*DIV + DIV/2) begin
        chk("stop_bit", 64'(tx), 64'(1));
        byte_q.push_back(dsh);
        dact = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1; end_uut = 0; rst_uut = 0;
    byte_q.delete(); start_q.delete(); exp_q.delete();
    @(negedge clk); rst = 0;
  endtask

  task automatic cap_pulse(input logic [63:0] p, input int low);
    @(negedge clk); block_o_uut = p; end_uut = 1;
    @(negedge clk); end_uut = 0;
    repeat (low) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (count_o !== 16'(target) && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_count"}, 64'(count_o), 64'(target));
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nbytes"}, 64'(byte_q.size()), 64'(10 * exp_q.size()));
    for (int f = 0; f < exp_q.size(); f++)
      for (int i = 0; i < 10; i++)
        if (f*10 + i < byte_q.size())
          chk({tag, "_byte"}, 64'(byte_q[f*10 + i]), 64'(fbyte(exp_q[f], i)));
    exp_q.delete(); byte_q.delete(); start_q.delete();
  endtask

  initial begin
    int k0, n;
    logic [63:0] p;
    rst = 1; rst_uut = 0; end_uut = 0; block_o_uut = '0;
    #1;
    chk("rst_tx", 64'(tx), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_count", 64'(count_o), 64'(0));
    do_reset();

    // Single result: latency, exact frame length, decoded bytes
    @(negedge clk); block_o_uut = 64'h0123456789ABCDEF; end_uut = 1;
    exp_q.push_back(64'h0123456789ABCDEF);
    @(posedge clk); #1; k0 = cyc;
    repeat (1002) @(negedge clk);
    chk("t2_cyc", 64'(cyc), 64'(k0 + 1001));
    chk("t2_count_before", 64'(count_o), 64'(0));
    chk("t2_busy_before", 64'(busy), 64'(1));
    @(negedge clk);
    chk("t2_count_after", 64'(count_o), 64'(1));
    chk("t2_busy_after", 64'(busy), 64'(0));
    chk("t2_latency", 64'(start_q.size() > 0 ? start_q[0] : -1), 64'(k0 + 2));
    end_uut = 0;
    check_frames("t2");

    // Held end_uut gives one capture; second capture after a UUT reset pulse
    do_reset();
    @(negedge clk); block_o_uut = 64'hDEADBEEF00C0FFEE; end_uut = 1;
    exp_q.push_back(64'hDEADBEEF00C0FFEE);
    repeat (50) @(negedge clk);
    end_uut = 0; block_o_uut = 64'h1122334455667788;
    @(negedge clk); rst_uut = 1;
    @(negedge clk); rst_uut = 0; end_uut = 1;
    exp_q.push_back(64'h1122334455667788);
    repeat (5) @(negedge clk); end_uut = 0;
    wait_done("t3", 2, 2500);
    check_frames("t3");

    // Overflow: six captures 3 cycles apart, the sixth is dropped
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      p = {$urandom, $urandom};
      p[7:0] = 8'(i);
      if (i <= 5) exp_q.push_back(p);
      cap_pulse(p, 2);
    end
    chk("t4_ovf_early", 64'(overflow), 64'(1));
    wait_done("t4", 5, 5600);
    chk("t4_ovf", 64'(overflow), 64'(1));
    check_frames("t4");

    // Asynchronous reset mid-frame with overflow and count set
    cap_pulse(64'h0F0F0F0F0F0F0F0F, 2);
    repeat (300) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t1_tx", 64'(tx), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_ovf", 64'(overflow), 64'(0));
    chk("t1_count", 64'(count_o), 64'(0));
    do_reset();

    // Gated capture while the UUT is in reset
    @(negedge clk); rst_uut = 1; block_o_uut = 64'hAAAA5555AAAA5555;
    @(negedge clk); end_uut = 1;
    repeat (60) @(negedge clk);
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_nbytes", 64'(byte_q.size()), 64'(0));
    chk("t5_count", 64'(count_o), 64'(0));
    end_uut = 0; rst_uut = 0;
    @(negedge clk);

    // Abort during the fourth byte, then a clean frame
    do_reset();
    cap_pulse(64'hFEDCBA9876543210, 2);
    n = 0;
    while (byte_q.size() < 3 && n < 1000) begin @(negedge clk); n++; end
    chk("t6_reach", 64'(byte_q.size()), 64'(3));
    repeat (15) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t6_tx", 64'(tx), 64'(1));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_count", 64'(count_o), 64'(0));
    do_reset();
    exp_q.push_back(64'h0A1B2C3D4E5F6071);
    cap_pulse(64'h0A1B2C3D4E5F6071, 2);
    wait_done("t6", 1, 1200);
    check_frames("t6");

    // Random bursts that fit the FIFO
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        p = {$urandom, $urandom};
        exp_q.push_back(p);
        cap_pulse(p, $urandom_range(2, 7));
      end
      chk("rnd_ovf", 64'(overflow), 64'(0));
      wait_done("rnd", n, n*1100 + 200);
      check_frames("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
